// File: rtl/bitpack_if.sv
// Read/write FIFO port bundle for bitpack_batch_wrapper.
// master: the wrapper (issues bursts, consumes read data, produces write data).
// slave:  the FIFO/memory side.
interface bitpack_if;
  logic [31:0] read_addr;
  logic [15:0] read_count;
  logic        read_req;
  logic        read_busy;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_ready;

  logic [31:0] write_addr;
  logic [15:0] write_count;
  logic        write_req;
  logic        write_busy;
  logic [31:0] write_data;
  logic        write_valid;
  logic        write_ready;

  modport master (
    output read_addr, read_count, read_req, read_ready,
    input  read_busy, read_data, read_valid,
    output write_addr, write_count, write_req, write_data, write_valid,
    input  write_busy, write_ready
  );

  modport slave (
    input  read_addr, read_count, read_req, read_ready,
    output read_busy, read_data, read_valid,
    input  write_addr, write_count, write_req, write_data, write_valid,
    output write_busy, write_ready
  );
endinterface

// File: rtl/bitpack_batch_wrapper.sv
// Batch wrapper for a stochastic-computing circuit: per batch element it reads
// compare/seed pairs for every source channel, runs the bitstream generators for
// the job length, then writes out one ones-count per destination channel.
// Optional job cycle counter: define BITPACK_CYCLE_COUNT_EN.
module bitpack_batch_wrapper #(
  parameter int unsigned SRC_SIZE = 2,
  parameter int unsigned DST_SIZE = 1,
  parameter int unsigned MODE_LEN = 2,
  parameter logic [SRC_SIZE*MODE_LEN-1:0] SRC_MODE = '0,
  parameter logic [DST_SIZE*MODE_LEN-1:0] DST_MODE = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                go_i,
  output logic                done_o,
  input  logic [31:0]         src_i,
  input  logic [31:0]         dst_i,
  input  logic [31:0]         size_i,
  input  logic [15:0]         batch_i,
  output logic [15:0]         batch_idx_o,
  bitpack_if.master           fifo_io,
  output logic [SRC_SIZE-1:0] sn_out_p_o,
  output logic [SRC_SIZE-1:0] sn_out_n_o,
  input  logic [DST_SIZE-1:0] sn_in_p_i,
  input  logic [DST_SIZE-1:0] sn_in_n_i,
  output logic [31:0]         cycles_o
);

  typedef enum logic [2:0] {StIdle, StRreq, StRead, StProc, StWrite, StNext, StFini} state_e;

  localparam logic [31:0] RdStride  = 32'(SRC_SIZE * 8);
  localparam logic [31:0] WrStride  = 32'(DST_SIZE * 4);
  localparam logic [15:0] RdCount   = 16'(SRC_SIZE * 2);
  localparam logic [15:0] WrCount   = 16'(DST_SIZE);
  localparam logic [6:0]  RdLast    = 7'(SRC_SIZE * 2 - 1);
  localparam logic [5:0]  WrLast    = 6'(DST_SIZE - 1);
  localparam logic [31:0] LfsrInit  = 32'h0000_0001;
  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;

  state_e      state_q;
  logic [15:0] batch_idx_q, batch_q;
  logic [31:0] size_q, proc_left_q;
  logic [6:0]  rd_idx_q;
  logic [5:0]  wr_idx_q;
  logic [31:0] read_addr_q, write_addr_q;
  logic [15:0] read_count_q, write_count_q;
  logic        read_req_q, write_req_q;

  logic proc_en, rd_fire, wr_fire, in_proc;

  // The last processing cycle is withheld while the write port is busy so the
  // count is never advanced past the job length.
  assign in_proc = (state_q == StProc);
  assign proc_en = in_proc && ((proc_left_q != 32'd1) || !fifo_io.write_busy);
  assign rd_fire = (state_q == StRead) && fifo_io.read_valid;
  assign wr_fire = (state_q == StWrite) && fifo_io.write_ready;

  // Job sequencer and registered bus controls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      batch_idx_q   <= '0;
      batch_q       <= '0;
      size_q        <= '0;
      proc_left_q   <= '0;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      read_addr_q   <= '0;
      write_addr_q  <= '0;
      read_count_q  <= '0;
      write_count_q <= '0;
      read_req_q    <= 1'b0;
      write_req_q   <= 1'b0;
    end else begin
      read_req_q  <= 1'b0;
      write_req_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            state_q       <= StRreq;
            batch_idx_q   <= '0;
            batch_q       <= (batch_i == 16'd0) ? 16'd1 : batch_i;
            size_q        <= (size_i == 32'd0) ? 32'd1 : size_i;
            read_addr_q   <= src_i;
            write_addr_q  <= dst_i;
            read_count_q  <= RdCount;
            write_count_q <= WrCount;
          end
        end
        StRreq: begin
          if (!fifo_io.read_busy) begin
            read_req_q <= 1'b1;
            rd_idx_q   <= '0;
            state_q    <= StRead;
          end
        end
        StRead: begin
          if (fifo_io.read_valid) begin
            if (rd_idx_q == RdLast) begin
              proc_left_q <= size_q;
              state_q     <= StProc;
            end else begin
              rd_idx_q <= rd_idx_q + 7'd1;
            end
          end
        end
        StProc: begin
          if (proc_left_q == 32'd1) begin
            if (!fifo_io.write_busy) begin
              write_req_q <= 1'b1;
              wr_idx_q    <= '0;
              state_q     <= StWrite;
            end
          end else begin
            proc_left_q <= proc_left_q - 32'd1;
          end
        end
        StWrite: begin
          if (fifo_io.write_ready) begin
            if (wr_idx_q == WrLast) state_q <= StNext;
            else                    wr_idx_q <= wr_idx_q + 6'd1;
          end
        end
        StNext: begin
          if (batch_idx_q == batch_q - 16'd1) begin
            state_q <= StFini;
          end else begin
            batch_idx_q  <= batch_idx_q + 16'd1;
            read_addr_q  <= read_addr_q + RdStride;
            write_addr_q <= write_addr_q + WrStride;
            state_q      <= StRreq;
          end
        end
        StFini: begin
          if (!go_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Source channels: a compare register against a Galois LFSR seeded from memory.
  for (genvar i = 0; i < SRC_SIZE; i++) begin : g_sn_gen
    localparam bit Invert = SRC_MODE[i*MODE_LEN];
    logic [31:0] cmp_q, lfsr_q;
    logic        bit_w;

    // Load compare/seed from the read burst; step the LFSR while processing.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cmp_q  <= '0;
        lfsr_q <= LfsrInit;
      end else begin
        if (rd_fire && (rd_idx_q == 7'(2 * i))) cmp_q <= fifo_io.read_data;
        if (rd_fire && (rd_idx_q == 7'(2 * i + 1))) begin
          // A zero seed would lock the LFSR at zero.
          lfsr_q <= (fifo_io.read_data == 32'd0) ? LfsrInit : fifo_io.read_data;
        end else if (proc_en) begin
          lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
        end
      end
    end

    // <= makes compare 0 a constant-0 stream and 0xFFFFFFFF a constant-1 stream.
    assign bit_w         = (lfsr_q <= cmp_q) ^ Invert;
    assign sn_out_p_o[i] = in_proc & bit_w;
    assign sn_out_n_o[i] = in_proc & ~bit_w;
  end

  // Destination counters form a shift chain toward channel 0 for write-out.
  logic [32*(DST_SIZE+1)-1:0] chain_w;
  assign chain_w[32*DST_SIZE +: 32] = 32'h0;

  for (genvar k = 0; k < DST_SIZE; k++) begin : g_count_ones
    localparam bit UseN = DST_MODE[k*MODE_LEN];
    logic [31:0] cnt_q;
    logic        bit_in;

    assign bit_in                = UseN ? sn_in_n_i[k] : sn_in_p_i[k];
    assign chain_w[32*k +: 32]   = cnt_q;

    // Count ones while processing; shift out (zero fill) on each accepted word.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        cnt_q <= '0;
      else if (proc_en) cnt_q <= cnt_q + 32'(bit_in);
      else if (wr_fire) cnt_q <= chain_w[32*(k+1) +: 32];
    end
  end

`ifdef BITPACK_CYCLE_COUNT_EN
  logic [31:0] cycles_q;

  // Cycles spent in an active job; frozen while idle or finished.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           cycles_q <= '0;
    else if ((state_q == StIdle) && go_i)                cycles_q <= '0;
    else if ((state_q != StIdle) && (state_q != StFini)) cycles_q <= cycles_q + 32'd1;
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

  assign done_o              = (state_q == StIdle);
  assign batch_idx_o         = batch_idx_q;
  assign fifo_io.read_addr   = read_addr_q;
  assign fifo_io.read_count  = read_count_q;
  assign fifo_io.read_req    = read_req_q;
  assign fifo_io.read_ready  = (state_q == StRead);
  assign fifo_io.write_addr  = write_addr_q;
  assign fifo_io.write_count = write_count_q;
  assign fifo_io.write_req   = write_req_q;
  assign fifo_io.write_data  = chain_w[31:0];
  assign fifo_io.write_valid = (state_q == StWrite);

endmodule

// File: tb/tb_bitpack_batch_wrapper.sv
// Directed bench for bitpack_batch_wrapper (SRC_SIZE=2, DST_SIZE=3).
// Circuit under the wrapper: dst0 = src0 & src1, dst1 = src0, dst2 = src1.
module tb_bitpack_batch_wrapper;
  logic        clk, rst, go, done;
  logic [31:0] src, dst, size, cycles;
  logic [15:0] batch, batch_idx;
  logic [1:0]  sn_out_p, sn_out_n;
  logic [2:0]  sn_in_p, sn_in_n;

  bitpack_if bus ();

  bitpack_batch_wrapper #(.SRC_SIZE(2), .DST_SIZE(3), .MODE_LEN(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .go_i       (go),
    .done_o     (done),
    .src_i      (src),
    .dst_i      (dst),
    .size_i     (size),
    .batch_i    (batch),
    .batch_idx_o(batch_idx),
    .fifo_io    (bus),
    .sn_out_p_o (sn_out_p),
    .sn_out_n_o (sn_out_n),
    .sn_in_p_i  (sn_in_p),
    .sn_in_n_i  (sn_in_n),
    .cycles_o   (cycles)
  );

  assign sn_in_p = {sn_out_p[1], sn_out_p[0], sn_out_p[0] & sn_out_p[1]};
  assign sn_in_n = ~sn_in_p;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_tab [4][4];
  int          rd_row;
  logic        wr_toggle;
  logic [31:0] rd_addr_log[$], wr_addr_log[$], wr_words[$];
  logic [15:0] rd_cnt_log[$], wr_cnt_log[$], bidx_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cyc_exp(input logic [31:0] n);
`ifdef BITPACK_CYCLE_COUNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  // Bus observer.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.read_req) begin
        rd_addr_log.push_back(bus.read_addr);
        rd_cnt_log.push_back(bus.read_count);
        bidx_log.push_back(batch_idx);
      end
      if (bus.write_req) begin
        wr_addr_log.push_back(bus.write_addr);
        wr_cnt_log.push_back(bus.write_count);
      end
      if (bus.write_valid && bus.write_ready) wr_words.push_back(bus.write_data);
    end
  end

  // Read FIFO: sees the request, then streams four words back to back.
  initial begin
    int row;
    bus.read_valid = 1'b0;
    bus.read_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.read_req && !rst) begin
        row = rd_row % 4;
        rd_row++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
          bus.read_valid = 1'b1;
          bus.read_data  = rd_tab[row][k];
          @(posedge clk);
          #1;
        end
        bus.read_valid = 1'b0;
      end
    end
  end

  // Write FIFO ready: constant or toggling.
  initial begin
    bus.write_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.write_ready = wr_toggle ? ~bus.write_ready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input logic v, input string tag);
    int n = 0;
    while (done !== v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'(v));
  endtask

  task automatic wait_words(input int num, input string tag);
    int n = 0;
    while (wr_words.size() < num && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(wr_words.size()), 32'(num));
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] sz,
                           input logic [15:0] b);
    rd_addr_log.delete(); wr_addr_log.delete(); wr_words.delete();
    rd_cnt_log.delete();  wr_cnt_log.delete();  bidx_log.delete();
    rd_row = 0;
    src = s; dst = d; size = sz; batch = b;
    go = 1'b1;
    wait_done(1'b0, "start");
  endtask

  // Collect words, confirm GO held in FINI does not restart, then release GO.
  task automatic finish_job(input int num, input int reads);
    wait_words(num, "words");
    repeat (10) @(negedge clk);
    chk("fini_hold", 32'(done), 32'd0);
    chk("no_restart", 32'(rd_addr_log.size()), 32'(reads));
  endtask

  task automatic release_go();
    go = 1'b0;
    wait_done(1'b1, "done_back");
  endtask

  initial begin
    logic [31:0] exp_w [9];
    rst = 1'b1; go = 1'b0; src = '0; dst = '0; size = '0; batch = '0;
    bus.read_busy = 1'b0; bus.write_busy = 1'b0; wr_toggle = 1'b0; rd_row = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_bidx", 32'(batch_idx), 32'd0);
    chk("rst_rreq", 32'(bus.read_req), 32'd0);
    chk("rst_wreq", 32'(bus.write_req), 32'd0);
    chk("rst_raddr", bus.read_addr, 32'd0);
    chk("rst_rcount", 32'(bus.read_count), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_snout", 32'(sn_out_p), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Job 1: half-probability streams on both sources, long bitstream.
    rd_tab[0] = '{32'h8000_0000, 32'h1234_5678, 32'h8000_0000, 32'h9ABC_DEF1};
    start_job(32'h100, 32'h200, 32'd256, 16'd1);
    finish_job(3, 1);
    chk("j1_raddr", rd_addr_log[0], 32'h100);
    chk("j1_rcount", 32'(rd_cnt_log[0]), 32'd4);
    chk("j1_waddr", wr_addr_log[0], 32'h200);
    chk("j1_wcount", 32'(wr_cnt_log[0]), 32'd3);
    chk("j1_and_range", 32'(wr_words[0] >= 16 && wr_words[0] <= 112), 32'd1);
    chk("j1_s0_range", 32'(wr_words[1] >= 64 && wr_words[1] <= 192), 32'd1);
    chk("j1_s1_range", 32'(wr_words[2] >= 64 && wr_words[2] <= 192), 32'd1);
    // RREQ 1 + READ 5 + PROC 256 + WRITE 3 + NEXT 1
    chk("j1_cycles_fini", cycles, cyc_exp(32'd266));
    release_go();
    repeat (3) @(negedge clk);
    chk("j1_cycles_idle", cycles, cyc_exp(32'd266));

    // Job 2: three elements, toggling write ready, distinct patterns per element.
    rd_tab[0] = '{32'hFFFF_FFFF, 32'd1, 32'h0, 32'd2};
    rd_tab[1] = '{32'h0, 32'd1, 32'hFFFF_FFFF, 32'd2};
    rd_tab[2] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd2};
    wr_toggle = 1'b1;
    start_job(32'h1000, 32'h2000, 32'd8, 16'd3);
    finish_job(9, 3);
    exp_w = '{0, 8, 0, 0, 0, 8, 8, 8, 8};
    for (int e = 0; e < 3; e++) begin
      chk("j2_raddr", rd_addr_log[e], 32'h1000 + 32'(e) * 32'h10);
      chk("j2_bidx", 32'(bidx_log[e]), 32'(e));
      chk("j2_waddr", wr_addr_log[e], 32'h2000 + 32'(e) * 32'hC);
    end
    for (int w = 0; w < 9; w++) chk("j2_word", wr_words[w], exp_w[w]);
    release_go();
    wr_toggle = 1'b0;

    // Job 3: zero batch/size, both ports initially busy.
    rd_tab[0] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd6};
    bus.read_busy = 1'b1; bus.write_busy = 1'b1;
    start_job(32'h40, 32'h80, 32'd0, 16'd0);
    repeat (5) @(negedge clk);
    chk("j3_rbusy_hold", 32'(rd_addr_log.size()), 32'd0);
    bus.read_busy = 1'b0;
    repeat (20) @(negedge clk);
    chk("j3_read_once", 32'(rd_addr_log.size()), 32'd1);
    chk("j3_wbusy_hold", 32'(wr_addr_log.size()), 32'd0);
    bus.write_busy = 1'b0;
    finish_job(3, 1);
    chk("j3_writes", 32'(wr_addr_log.size()), 32'd1);
    for (int w = 0; w < 3; w++) chk("j3_word", wr_words[w], 32'd1);
    release_go();

    // Job 4: reset in the middle of processing batch element 1.
    start_job(32'h3000, 32'h4000, 32'd50, 16'd2);
    begin
      int n = 0;
      while (rd_addr_log.size() < 2 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("j4_second_read", 32'(rd_addr_log.size()), 32'd2);
    repeat (10) @(negedge clk);
    go = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("j4_rst_done", 32'(done), 32'd1);
    chk("j4_rst_bidx", 32'(batch_idx), 32'd0);
    chk("j4_rst_wreq", 32'(bus.write_req), 32'd0);
    chk("j4_rst_snout", 32'(sn_out_p), 32'd0);
    #2 rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("j4_writes", 32'(wr_addr_log.size()), 32'd1);
    chk("j4_reads", 32'(rd_addr_log.size()), 32'd2);
    chk("j4_idle", 32'(done), 32'd1);

    // Job 5: clean run after reset, zero-wait FIFOs.
    start_job(32'hFFFF_FFF8, 32'h500, 32'd4, 16'd1);
    finish_job(3, 1);
    chk("j5_raddr", rd_addr_log[0], 32'hFFFF_FFF8);
    chk("j5_waddr", wr_addr_log[0], 32'h500);
    for (int w = 0; w < 3; w++) chk("j5_word", wr_words[w], 32'd4);
    // RREQ 1 + READ 5 + PROC 4 + WRITE 3 + NEXT 1
    chk("j5_cycles", cycles, cyc_exp(32'd14));
    release_go();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
